activation_pingpong_memory: RTL and testbench

ACTIVATION_PINGPONG_MEMORY -- requirements
Module: activation_pingpong_memory

---
 rtl/activation_pingpong_memory.sv | 142 ++++++++++++++
 tb/tb_activation_pingpong_memory.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/activation_pingpong_memory.sv
// Double-buffered multi-bank activation store with a two-stage, lane-muxed read path.
// Define ACT_MEM_ZERO_PAD_EN to add the rd_pad input for per-lane zero padding.
module activation_pingpong_memory #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BRAM_COUNT = 5,
    localparam int SEL_W     = (BRAM_COUNT > 1) ? $clog2(BRAM_COUNT) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [BRAM_COUNT-1:0]            wr_en_bus,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             wr_last,
    input  logic                             rd_req,
    output logic                             rd_ready,
    input  logic [BRAM_COUNT*ADDR_WIDTH-1:0] rd_addr,
    input  logic [BRAM_COUNT*SEL_W-1:0]      rd_sels,
`ifdef ACT_MEM_ZERO_PAD_EN
    input  logic [BRAM_COUNT-1:0]            rd_pad,
`endif
    input  logic                             rd_done,
    output logic                             rd_valid,
    output logic [BRAM_COUNT*DATA_WIDTH-1:0] rd_data,
    output logic                             wr_half,
    output logic                             rd_half
);

    localparam int DEPTH = 2 * (2 ** ADDR_WIDTH);

    logic [1:0]                      r_full;
    logic                            r_wr_half;
    logic                            r_rd_half;
    logic                            r_s1_valid;
    logic [BRAM_COUNT*SEL_W-1:0]     r_s1_sels;
    logic                            r_rd_valid;
    logic [BRAM_COUNT*DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0]           w_s1_data [BRAM_COUNT];
    logic [BRAM_COUNT*DATA_WIDTH-1:0] w_lane_data;
    logic [SEL_W-1:0]                w_sel;
    logic                            w_wr_fire;
    logic                            w_rd_fire;
    logic                            w_release;
`ifdef ACT_MEM_ZERO_PAD_EN
    logic [BRAM_COUNT-1:0]           r_s1_pad;
`endif

    assign wr_ready  = !r_full[r_wr_half];
    assign rd_ready  = r_full[r_rd_half];
    assign w_wr_fire = wr_valid && wr_ready;
    assign w_rd_fire = rd_req && rd_ready;
    assign w_release = rd_done && rd_ready;

    // Set needs an empty write half, clear needs a full read half, so both can never hit one bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= '0;
            r_wr_half <= 1'b0;
            r_rd_half <= 1'b0;
        end else begin
            if (w_wr_fire && wr_last) begin
                r_full[r_wr_half] <= 1'b1;
                r_wr_half         <= ~r_wr_half;
            end
            if (w_release) begin
                r_full[r_rd_half] <= 1'b0;
                r_rd_half         <= ~r_rd_half;
            end
        end
    end

    for (genvar gi = 0; gi < BRAM_COUNT; gi++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [DATA_WIDTH-1:0] r_q;
        logic [ADDR_WIDTH-1:0] w_rd_addr;

        assign w_rd_addr     = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_s1_data[gi] = r_q;

        always_ff @(posedge clk) begin
            if (w_wr_fire && wr_en_bus[gi]) begin
                r_mem[{r_wr_half, wr_addr}] <= wr_data;
            end
            if (w_rd_fire) begin
                r_q <= r_mem[{r_rd_half, w_rd_addr}];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sels  <= '0;
`ifdef ACT_MEM_ZERO_PAD_EN
            r_s1_pad   <= '0;
`endif
        end else begin
            r_s1_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_s1_sels <= rd_sels;
`ifdef ACT_MEM_ZERO_PAD_EN
                r_s1_pad  <= rd_pad;
`endif
            end
        end
    end

    always_comb begin
        w_lane_data = '0;
        w_sel       = '0;
        for (int unsigned j = 0; j < BRAM_COUNT; j++) begin
            w_sel = r_s1_sels[j*SEL_W +: SEL_W];
            if ({1'b0, w_sel} < (SEL_W + 1)'(BRAM_COUNT)
`ifdef ACT_MEM_ZERO_PAD_EN
                && !r_s1_pad[j]
`endif
            ) begin
                w_lane_data[j*DATA_WIDTH +: DATA_WIDTH] = w_s1_data[w_sel];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rd_data <= w_lane_data;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign wr_half  = r_wr_half;
    assign rd_half  = r_rd_half;

endmodule

// File: tb/tb_activation_pingpong_memory.sv
// Directed bench for activation_pingpong_memory; exercises the ACT_MEM_ZERO_PAD_EN lane padding when defined.
module tb_activation_pingpong_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_en_bus;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_last;
    logic        rd_req;
    logic        rd_ready;
    logic [19:0] rd_addr;
    logic [14:0] rd_sels;
    logic        rd_done;
    logic        rd_valid;
    logic [39:0] rd_data;
    logic        wr_half;
    logic        rd_half;
`ifdef ACT_MEM_ZERO_PAD_EN
    logic [4:0]  rd_pad;
`endif

    int n_cmp = 0;
    int n_err = 0;

    activation_pingpong_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .BRAM_COUNT(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_en_bus(wr_en_bus),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_sels(rd_sels),
`ifdef ACT_MEM_ZERO_PAD_EN
        .rd_pad(rd_pad),
`endif
        .rd_done(rd_done), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_half(wr_half), .rd_half(rd_half)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] sels5(input int s0, input int s1, input int s2,
                                          input int s3, input int s4);
        return {3'(s4), 3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    endfunction

    function automatic logic [19:0] addr5(input int a0, input int a1, input int a2,
                                          input int a3, input int a4);
        return {4'(a4), 4'(a3), 4'(a2), 4'(a1), 4'(a0)};
    endfunction

    task automatic wr_beat(input logic [4:0] en, input int addr, input int data, input logic last);
        wr_valid  = 1'b1;
        wr_en_bus = en;
        wr_addr   = 4'(addr);
        wr_data   = 8'(data);
        wr_last   = last;
        tick();
        wr_valid  = 1'b0;
        wr_last   = 1'b0;
        wr_en_bus = '0;
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_en_bus = '0; wr_addr = '0; wr_data = '0;
        wr_last = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_sels = '0; rd_done = 1'b0;
`ifdef ACT_MEM_ZERO_PAD_EN
        rd_pad = '0;
`endif
        tick(); tick();
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_halves", {wr_half, rd_half}, 0);
        rst_n = 1'b1;
        tick();

        // Fill half 0: bank i, addr a holds 16*i+a
        for (int i = 0; i < 5; i++)
            for (int a = 0; a < 16; a++)
                wr_beat(5'(1 << i), a, 16 * i + a, (i == 4) && (a == 15));
        chk("fill0_wr_half", wr_half, 1);
        chk("fill0_rd_ready", rd_ready, 1);
        chk("fill0_wr_ready", wr_ready, 1);

        // Identity read at addr 3
        rd_addr = addr5(3, 3, 3, 3, 3);
        rd_sels = sels5(0, 1, 2, 3, 4);
        rd_req  = 1'b1;
        tick();
        rd_req  = 1'b0;
        chk("id_lat1_valid", rd_valid, 0);
        tick();
        chk("id_valid", rd_valid, 1);
        chk("id_data", rd_data, 40'h43_33_23_13_03);
        tick();
        chk("id_valid_pulse", rd_valid, 0);

        // Back-to-back: reversed sels, then lane 1 sel=7 with per-bank addresses
        rd_addr = addr5(5, 5, 5, 5, 5);
        rd_sels = sels5(4, 3, 2, 1, 0);
        rd_req  = 1'b1;
        tick();
        rd_addr = addr5(1, 2, 3, 4, 5);
        rd_sels = sels5(0, 7, 2, 3, 4);
        tick();
        rd_req  = 1'b0;
        chk("rev_valid", rd_valid, 1);
        chk("rev_data", rd_data, 40'h05_15_25_35_45);
        tick();
        chk("sel7_valid", rd_valid, 1);
        chk("sel7_data", rd_data, 40'h45_34_23_00_01);
        tick();
        chk("b2b_valid_end", rd_valid, 0);

        // Fill half 1, including a zero-enable beat that must not write
        wr_beat(5'b11111, 1, 8'hB1, 1'b0);
        wr_beat(5'b00000, 1, 8'hEE, 1'b0);
        wr_beat(5'b11111, 2, 8'hC2, 1'b1);
        chk("both_full_wr_ready", wr_ready, 0);
        chk("both_full_wr_half", wr_half, 0);
        wr_beat(5'b11111, 3, 8'h99, 1'b0);
        rd_addr = addr5(3, 3, 3, 3, 3);
        rd_sels = sels5(0, 1, 2, 3, 4);
        rd_req  = 1'b1;
        tick();
        rd_req  = 1'b0;
        tick();
        chk("blocked_wr_data", rd_data, 40'h43_33_23_13_03);

        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("release_wr_ready", wr_ready, 1);
        chk("release_rd_half", rd_half, 1);
        chk("release_rd_ready", rd_ready, 1);

        // Read and release in the same cycle
        rd_addr = addr5(1, 1, 1, 1, 1);
        rd_req  = 1'b1;
        rd_done = 1'b1;
        tick();
        rd_req  = 1'b0;
        rd_done = 1'b0;
        chk("rr_rd_ready", rd_ready, 0);
        chk("rr_rd_half", rd_half, 0);
        tick();
        chk("rr_valid", rd_valid, 1);
        chk("rr_data", rd_data, 40'hB1_B1_B1_B1_B1);

        // Request and release with nothing readable
        rd_req  = 1'b1;
        rd_done = 1'b1;
        tick();
        rd_req  = 1'b0;
        rd_done = 1'b0;
        tick();
        chk("empty_rd_valid", rd_valid, 0);
        chk("empty_halves", {wr_half, rd_half}, 0);
        chk("empty_wr_ready", wr_ready, 1);

        // wr_last on one half together with rd_done on the other
        wr_beat(5'b11111, 4, 8'hD4, 1'b1);
        chk("d4_rd_ready", rd_ready, 1);
        rd_done = 1'b1;
        wr_beat(5'b11111, 4, 8'hE4, 1'b1);
        rd_done = 1'b0;
        chk("concurrent_halves", {wr_half, rd_half}, 2'b01);
        chk("concurrent_ready", {wr_ready, rd_ready}, 2'b11);

        // Reset with reads in flight
        rd_addr = addr5(4, 4, 4, 4, 4);
        rd_req  = 1'b1;
        tick();
        tick();
        rd_req  = 1'b0;
        chk("inflight_valid", rd_valid, 1);
        chk("inflight_data", rd_data, 40'hE4_E4_E4_E4_E4);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", rd_valid, 0);
        chk("async_rst_data", rd_data, 0);
        chk("async_rst_ready", {wr_ready, rd_ready}, 2'b10);
        chk("async_rst_halves", {wr_half, rd_half}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid_a", rd_valid, 0);
        tick();
        chk("post_rst_valid_b", rd_valid, 0);

        // Memory survives reset
        wr_beat(5'b00000, 0, 0, 1'b1);
        rd_addr = addr5(4, 4, 4, 4, 4);
        rd_sels = sels5(0, 1, 2, 3, 4);
        rd_req  = 1'b1;
        tick();
        rd_req  = 1'b0;
        tick();
        chk("retain_data", rd_data, 40'hD4_D4_D4_D4_D4);

`ifdef ACT_MEM_ZERO_PAD_EN
        rd_pad = 5'b00101;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        rd_pad = '0;
        tick();
        chk("pad_valid", rd_valid, 1);
        chk("pad_data", rd_data, 40'hD4_D4_00_D4_00);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
